// File: rtl/apb_requester.sv
// APB requester: turns single cmd_* requests into one APB SETUP/ACCESS transfer and returns a rsp_* pulse.
// Optional ACCESS-phase timeout is compiled in with `define APB_REQUESTER_TIMEOUT_EN.
module apb_requester #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    // cmd handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and cmd_* are ignored at every other edge.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_error,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [DATA_W/8-1:0]   PSTRB,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PERROR,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_error_q, rsp_error_d;

`ifdef APB_REQUESTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
`ifdef APB_REQUESTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d  = ST_SETUP;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    // Reads present an all-zero data/strobe pattern on the bus.
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    pstrb_d  = cmd_write ? cmd_strb : '0;
`ifdef APB_REQUESTER_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end

            ST_SETUP: begin
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (PREADY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = PERROR;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end
`ifdef APB_REQUESTER_TIMEOUT_EN
                // The last permitted wait cycle ends the transfer as an error unless PREADY wins.
                else if (wait_cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

`ifdef APB_REQUESTER_TIMEOUT_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign PSEL      = (state_q != ST_IDLE);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign dbg_state = state_q;

endmodule
